// File: rtl/sd_dma_mb_if.sv
// Control, SD data-line and SRAM write-port bundle for sd_dma_mb.
interface sd_dma_mb_if #(parameter int CNT_W = 12);
  logic             en;
  logic [7:0]       blkcnt;
  logic             partial;
  logic [CNT_W-1:0] partial_start;
  logic [CNT_W-1:0] partial_end;
  logic [3:0]       sd_dat;
  logic             status;
  logic             sram_we;
  logic             nextaddr;
  logic [7:0]       sram_data;
  logic             timeout;
  logic             crcerr;

  modport master (output en, blkcnt, partial, partial_start, partial_end, sd_dat,
                  input  status, sram_we, nextaddr, sram_data, timeout, crcerr);
  modport slave  (input  en, blkcnt, partial, partial_start, partial_end, sd_dat,
                  output status, sram_we, nextaddr, sram_data, timeout, crcerr);
endinterface

// File: rtl/sd_dma_mb.sv
// Multi-block SD 4-bit read DMA: start-bit hunt, nibble packing, windowed SRAM writes.
// Optional per-line CRC16 check enabled by defining SD_DMA_CRC_CHECK_EN.
module sd_dma_mb #(
  parameter int BLOCK_BYTES = 512,
  parameter int CLKDIV      = 4,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        sd_clk,
  sd_dma_mb_if.slave bus
);
  localparam int DIV_W = $clog2(CLKDIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLKDIV / 2);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(15);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_STOP, S_DONE} state_t;
  state_t state, state_nx;

  logic [2:0]       en_sync;
  logic [DIV_W-1:0] div, wcnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] byte_idx, byte_nx, p_start, p_end;
  logic [7:0]       blks_left, data_q;
  logic [3:0]       hi;
  logic             phase, first_blk, p_en, status_q, timeout_q, crcerr_q, we_q, na_q;
  logic             en_rise, clk_oe, smp, last_blk, in_win, stop_early, wr_go;

  assign en_rise    = en_sync[1] & ~en_sync[2];
  assign clk_oe     = state inside {S_WAIT, S_DATA, S_CRC, S_STOP};
  assign smp        = clk_oe && (div == DIV_LAST);
  assign sd_clk     = clk_oe ? (div >= DIV_HALF) : 1'bz;
  assign last_blk   = (blks_left == 8'd1);
  assign byte_nx    = byte_idx + CNT_W'(1);
  assign in_win     = (!p_en || !first_blk || byte_idx >= p_start) &&
                      (!p_en || !last_blk  || byte_idx <  p_end);
  assign stop_early = p_en && last_blk && (byte_nx >= p_end);

  assign bus.status    = status_q;
  assign bus.sram_we   = we_q;
  assign bus.nextaddr  = na_q;
  assign bus.sram_data = data_q;
  assign bus.timeout   = timeout_q;
  assign bus.crcerr    = crcerr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_go    = 1'b0;
    unique case (state)
      S_IDLE: if (en_rise) state_nx = S_WAIT;
      S_WAIT: if (smp) begin
        if (!bus.sd_dat[0])          state_nx = S_DATA;
        else if (tmo_cnt == TMO_LAST) state_nx = S_DONE;
      end
      S_DATA: if (smp && phase) begin
        wr_go = in_win;
        if (stop_early)                 state_nx = S_DONE;
        else if (byte_idx == BYTE_LAST) state_nx = S_CRC;
      end
      S_CRC:  if (smp && byte_idx == CRC_LAST) state_nx = S_STOP;
      S_STOP: if (smp) state_nx = last_blk ? S_DONE : S_WAIT;
      // Hold here until a write strobe and its address pulse have both finished.
      S_DONE: if (we_q && !na_q) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync   <= '0;
      div       <= '0;
      tmo_cnt   <= '0;
      byte_idx  <= '0;
      phase     <= 1'b0;
      hi        <= '0;
      blks_left <= '0;
      first_blk <= 1'b0;
      p_en      <= 1'b0;
      p_start   <= '0;
      p_end     <= '0;
      status_q  <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
    end else begin
      en_sync <= {en_sync[1:0], bus.en};
      div     <= (!clk_oe || div == DIV_LAST) ? '0 : div + DIV_W'(1);
      case (state)
        S_IDLE: if (en_rise) begin
          p_en      <= bus.partial;
          p_start   <= bus.partial_start;
          p_end     <= bus.partial_end;
          blks_left <= (bus.blkcnt == 8'd0) ? 8'd1 : bus.blkcnt;
          first_blk <= 1'b1;
          tmo_cnt   <= '0;
          timeout_q <= 1'b0;
          status_q  <= 1'b1;
        end
        S_WAIT: if (smp) begin
          if (!bus.sd_dat[0]) begin
            byte_idx <= '0;
            phase    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_LAST) timeout_q <= 1'b1;
          end
        end
        S_DATA: if (smp) begin
          phase <= ~phase;
          if (!phase) hi <= bus.sd_dat;
          else begin
            data_q   <= {hi, bus.sd_dat};
            byte_idx <= (byte_idx == BYTE_LAST) ? '0 : byte_nx;
          end
        end
        S_CRC:  if (smp) byte_idx <= (byte_idx == CRC_LAST) ? '0 : byte_nx;
        S_STOP: if (smp && !last_blk) begin
          blks_left <= blks_left - 8'd1;
          first_blk <= 1'b0;
          tmo_cnt   <= '0;
        end
        S_DONE: if (state_nx == S_IDLE) status_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Write strobe: low for CLKDIV clocks, then one address-advance pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b1;
      na_q <= 1'b0;
      wcnt <= '0;
    end else begin
      na_q <= 1'b0;
      if (wr_go) begin
        we_q <= 1'b0;
        wcnt <= DIV_LAST;
      end else if (!we_q) begin
        if (wcnt == '0) begin
          we_q <= 1'b1;
          na_q <= 1'b1;
        end else begin
          wcnt <= wcnt - DIV_W'(1);
        end
      end
    end
  end

`ifdef SD_DMA_CRC_CHECK_EN
  logic [3:0][15:0] crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= '0;
      crcerr_q <= 1'b0;
    end else if (state == S_IDLE && en_rise) begin
      crcerr_q <= 1'b0;
    end else if (smp) begin
      for (int i = 0; i < 4; i++) begin
        case (state)
          S_WAIT: crc[i] <= '0;
          S_DATA: crc[i] <= crc16_step(crc[i], bus.sd_dat[i]);
          S_CRC: begin
            if (bus.sd_dat[i] != crc[i][15]) crcerr_q <= 1'b1;
            crc[i] <= {crc[i][14:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end
`else
  assign crcerr_q = 1'b0;
`endif
endmodule

// File: tb/tb_sd_dma_mb.sv
// Directed bench for sd_dma_mb: behavioural SD card on the DAT lines plus SRAM write monitor.
module tb_sd_dma_mb;
  localparam int BB  = 512;
  localparam int CD  = 4;
  localparam int TMO = 4096;
  localparam int CW  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  wire  sd_clk;

  sd_dma_mb_if #(.CNT_W(CW)) bus ();

  sd_dma_mb #(.BLOCK_BYTES(BB), .CLKDIV(CD), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sd_clk(sd_clk),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Card: gap idles, start nibble, 1024 data nibbles (byte i = i&0xFF), 16 CRC nibbles, stop.
  logic        card_on = 1'b0;
  logic        c_flip  = 1'b0;
  int          c_gap   = 3;
  int          c_nblk  = 1;
  int          c_ph    = 0;
  int          c_cnt   = 0;
  int          c_blk   = 0;
  logic [3:0]  c_dat   = 4'hF;
  logic [7:0]  c_byte;
  logic [15:0] c_crc [4];

  assign bus.sd_dat = card_on ? c_dat : 4'hF;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always @(negedge sd_clk or negedge card_on) begin
    if (!card_on) begin
      c_ph = 0; c_cnt = 0; c_blk = 0; c_dat = 4'hF;
    end else begin
      case (c_ph)
        0: if (c_cnt < c_gap) begin
             c_dat = 4'hF; c_cnt++;
           end else begin
             c_dat = 4'h0; c_ph = 1; c_cnt = 0;
             for (int i = 0; i < 4; i++) c_crc[i] = 16'h0000;
           end
        1: begin
          c_byte = 8'(c_cnt / 2);
          c_dat  = c_cnt[0] ? c_byte[3:0] : c_byte[7:4];
          for (int i = 0; i < 4; i++) c_crc[i] = crc_upd(c_crc[i], c_dat[i]);
          c_cnt++;
          if (c_cnt == 2 * BB) begin c_ph = 2; c_cnt = 0; end
        end
        2: begin
          for (int i = 0; i < 4; i++) begin
            c_dat[i] = c_crc[i][15];
            c_crc[i] = {c_crc[i][14:0], 1'b0};
          end
          if (c_flip && c_blk == 0 && c_cnt == 5) c_dat[2] = ~c_dat[2];
          c_cnt++;
          if (c_cnt == 16) begin c_ph = 3; c_cnt = 0; end
        end
        3: begin
          c_dat = 4'hF; c_blk++;
          c_ph  = (c_blk < c_nblk) ? 0 : 4;
        end
        default: c_dat = 4'hF;
      endcase
    end
  end

  int         nw = 0, nna = 0, nlow = 0;
  logic       we_prev = 1'b1;
  logic [7:0] wq [$];

  always @(negedge clk) begin
    if (!bus.sram_we && we_prev) begin wq.push_back(bus.sram_data); nw++; end
    if (!bus.sram_we) nlow++;
    if (bus.nextaddr) nna++;
    we_prev = bus.sram_we;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int t, input int k);
    case (t)
      2:       return 8'(10 + k);
      3:       return (k < 12) ? 8'(500 + k) : (k < 524) ? 8'(k - 12) : 8'(k - 524);
      default: return 8'(k);
    endcase
  endfunction

  task automatic xfer_checks(input string tn, input int t, input int bw, input int bna,
                             input int blow, input int nexp);
    int errs;
    errs = 0;
    chk({tn, "_writes"},   nw - bw,     nexp);
    chk({tn, "_nextaddr"}, nna - bna,   nexp);
    chk({tn, "_we_low"},   nlow - blow, nexp * CD);
    for (int k = 0; k < nw - bw; k++)
      if (wq[bw + k] !== exp_byte(t, k)) errs++;
    chk({tn, "_data_errs"}, errs, 0);
  endtask

  task automatic start(input logic [7:0] blk, input logic part, input int st, input int en_end);
    @(negedge clk);
    bus.blkcnt        = blk;
    bus.partial       = part;
    bus.partial_start = CW'(st);
    bus.partial_end   = CW'(en_end);
    bus.en            = 1'b1;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (bus.status !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.status), 1);
  endtask

  task automatic wait_idle(input string tag, input int lim, output int cyc);
    cyc = 0;
    while (bus.status !== 1'b0 && cyc < lim) begin @(negedge clk); cyc++; end
    chk(tag, 32'(bus.status), 0);
  endtask

  task automatic end_xfer();
    bus.en  = 1'b0;
    card_on = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int bw, bna, blow, cyc, n;
    bus.en = 1'b0; bus.blkcnt = 8'd0; bus.partial = 1'b0;
    bus.partial_start = '0; bus.partial_end = '0;
    repeat (3) @(negedge clk);
    chk("rst_status",   32'(bus.status),    0);
    chk("rst_we",       32'(bus.sram_we),   1);
    chk("rst_nextaddr", 32'(bus.nextaddr),  0);
    chk("rst_data",     32'(bus.sram_data), 0);
    chk("rst_timeout",  32'(bus.timeout),   0);
    chk("rst_crcerr",   32'(bus.crcerr),    0);
    chk("rst_sdclk_oe", 32'(dut.clk_oe),    0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1: one full block
    bw = nw; bna = nna; blow = nlow;
    c_gap = 3; c_nblk = 1; c_flip = 1'b0; card_on = 1'b1;
    start(8'd1, 1'b0, 0, 0);
    wait_busy("t1_busy");
    wait_idle("t1_idle", 20000, cyc);
    xfer_checks("t1", 1, bw, bna, blow, BB);
    chk("t1_after_stop", 32'(c_ph >= 3), 1);
    chk("t1_timeout",    32'(bus.timeout), 0);
    chk("t1_crcerr",     32'(bus.crcerr),  0);
    chk("t1_sdclk_oe",   32'(dut.clk_oe),  0);
    end_xfer();

    // T2: window 10..19 in a single block, early stop
    bw = nw; bna = nna; blow = nlow;
    c_gap = 3; c_nblk = 1; card_on = 1'b1;
    start(8'd1, 1'b1, 10, 20);
    wait_busy("t2_busy");
    wait_idle("t2_idle", 20000, cyc);
    xfer_checks("t2", 2, bw, bna, blow, 10);
    chk("t2_early_stop", c_ph, 1);
    end_xfer();

    // T3: three blocks, window 500..end / all / 0..3, EN re-pulsed mid-transfer
    bw = nw; bna = nna; blow = nlow;
    c_gap = 7; c_nblk = 3; card_on = 1'b1;
    start(8'd3, 1'b1, 500, 4);
    wait_busy("t3_busy");
    repeat (300) @(negedge clk);
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    bus.en = 1'b1;
    wait_idle("t3_idle", 40000, cyc);
    xfer_checks("t3", 3, bw, bna, blow, 12 + BB + 4);
    chk("t3_last_block", c_blk, 2);
    chk("t3_early_stop", c_ph, 1);
    end_xfer();

    // T4: no start bit ever
    bw = nw;
    card_on = 1'b0;
    start(8'd1, 1'b0, 0, 0);
    wait_busy("t4_busy");
    wait_idle("t4_idle", 20000, cyc);
    chk("t4_timeout",     32'(bus.timeout), 1);
    chk("t4_duration_ok", 32'(cyc >= 16375 && cyc <= 16395), 1);
    chk("t4_writes",      nw - bw, 0);
    chk("t4_sdclk_oe",    32'(dut.clk_oe), 0);
    end_xfer();

`ifdef SD_DMA_CRC_CHECK_EN
    // T5: corrupted CRC bit on DAT[2]
    bw = nw; bna = nna; blow = nlow;
    c_gap = 3; c_nblk = 1; c_flip = 1'b1; card_on = 1'b1;
    start(8'd1, 1'b0, 0, 0);
    wait_busy("t5_busy");
    wait_idle("t5_idle", 20000, cyc);
    chk("t5_crcerr", 32'(bus.crcerr), 1);
    xfer_checks("t5", 1, bw, bna, blow, BB);
    c_flip = 1'b0;
    end_xfer();
`endif

    // T6: reset mid-transfer, then a clean transfer with BLKCNT=0
    bw = nw;
    c_gap = 3; c_nblk = 1; card_on = 1'b1;
    start(8'd1, 1'b0, 0, 0);
    wait_busy("t6_busy");
    n = 0;
    while ((nw - bw) < 100 && n < 20000) begin @(negedge clk); n++; end
    chk("t6_reached_100", 32'((nw - bw) >= 100), 1);
    #1;
    chk("t6_we_low_before_rst", 32'(bus.sram_we), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we",       32'(bus.sram_we),   1);
    chk("t6_rst_status",   32'(bus.status),    0);
    chk("t6_rst_sdclk_oe", 32'(dut.clk_oe),    0);
    chk("t6_rst_nextaddr", 32'(bus.nextaddr),  0);
    chk("t6_rst_data",     32'(bus.sram_data), 0);
    bus.en = 1'b0; card_on = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bw = nw; bna = nna; blow = nlow;
    card_on = 1'b1;
    start(8'd0, 1'b0, 0, 0);
    wait_busy("t6b_busy");
    wait_idle("t6b_idle", 20000, cyc);
    xfer_checks("t6b", 1, bw, bna, blow, BB);
    chk("t6b_timeout", 32'(bus.timeout), 0);
    end_xfer();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
